// File: rtl/debounce_pkg.sv
// Shared definitions for the pushbutton debouncer: state encoding and default parameters.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 8;
    localparam int DEF_REPEAT_RATE     = 4;
    localparam int DEF_CNT_W           = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_pulse_sync2.sv
// Two-flop synchronizer bringing the raw pushbutton level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/debounce_pulse.sv
// Pushbutton debouncer producing a one-cycle toggle strobe per qualified press.
// Optional auto-repeat while held is enabled by defining DEBOUNCE_AUTOREPEAT_EN.
//
// state        | meaning
// IDLE         | button released and accepted as released
// PRESS_WAIT   | synchronized level high, qualifying the press
// HELD         | press accepted, debounced level is high
// RELEASE_WAIT | synchronized level low, qualifying the release
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic t_pulse,
    output logic btn_level
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("debounce_pulse: cycle parameters must be 1 or more");
    end
    if (longint'(CNT_MAX) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cnt_w
        $error("debounce_pulse: CNT_W too narrow for the configured cycle counts");
    end

    logic             w_btn_sync;
    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_press_done;
    logic             w_rpt_pulse;
    logic             r_t_pulse;
    logic             r_btn_level;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (btn_in),
        .o_q   (w_btn_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // A bounce back to the previous level aborts qualification without a pulse.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_press_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_sync) begin
                    w_next_state = PRESS_WAIT;
                    w_next_cnt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_btn_sync) begin
                    w_next_state = IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_next_state = HELD;
                    w_press_done = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!w_btn_sync) begin
                    w_next_state = RELEASE_WAIT;
                    w_next_cnt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_btn_sync) begin
                    w_next_state = HELD;
                end else if (r_cnt == DB_LAST) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] r_rpt;
    logic             r_rpt_first;
    logic [CNT_W-1:0] w_rpt_last;
    logic             w_stay_held;

    assign w_rpt_last  = r_rpt_first ? RPT_DELAY_LAST : RPT_RATE_LAST;
    assign w_stay_held = (r_state == HELD) && w_btn_sync;
    assign w_rpt_pulse = w_stay_held && (r_rpt == w_rpt_last);

    // Any entry into HELD, including a return from RELEASE_WAIT, re-arms the long delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt       <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_stay_held) begin
            if (w_rpt_pulse) begin
                r_rpt       <= '0;
                r_rpt_first <= 1'b0;
            end else begin
                r_rpt <= r_rpt + CNT_W'(1);
            end
        end else begin
            r_rpt       <= '0;
            r_rpt_first <= 1'b1;
        end
    end
`else
    assign w_rpt_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t_pulse   <= 1'b0;
            r_btn_level <= 1'b0;
        end else begin
            r_t_pulse   <= w_press_done | w_rpt_pulse;
            r_btn_level <= (w_next_state == HELD) || (w_next_state == RELEASE_WAIT);
        end
    end

    assign t_pulse   = r_t_pulse;
    assign btn_level = r_btn_level;

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse: a run-length reference model predicts each cycle's outputs.
module tb_debounce_pulse;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RR = 4;

    logic clk;
    logic rst_n;
    logic btn_in;
    logic t_pulse;
    logic btn_level;

    int n_vec;
    int n_err;

    logic [1:0] exp_q[$];

    // Reference model: synchronizer pipe, accepted level, length of the current disagreeing run
    logic m_s1;
    logic m_s2;
    logic m_level;
    int   m_run;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    int   m_age;
`endif

    debounce_pulse #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .t_pulse   (t_pulse),
        .btn_level (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_level = 1'b0;
        m_run   = 0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        m_age   = 0;
`endif
    endtask

    // One cycle of stimulus; the expected outputs after the coming rising edge are queued.
    task automatic step(input logic b, input logic rn);
        logic p;
        logic prev_held;
        @(negedge clk);
        btn_in = b;
        rst_n  = rn;
        if (!rn) begin
            #1;
            n_vec++;
            if (t_pulse !== 1'b0 || btn_level !== 1'b0) begin
                n_err++;
                $display("FAIL rst_imm: got t_pulse=%b btn_level=%b, want 0 0", t_pulse, btn_level);
            end
            model_reset();
            exp_q.push_back(2'b00);
        end else begin
            p         = 1'b0;
            prev_held = m_level && (m_run == 0);
            if (m_s2 != m_level) m_run++;
            else m_run = 0;
            if (m_run == D + 1) begin
                m_level = !m_level;
                m_run   = 0;
                if (m_level) p = 1'b1;
            end
`ifdef DEBOUNCE_AUTOREPEAT_EN
            if (m_level && m_run == 0) begin
                if (prev_held) begin
                    m_age++;
                    if (m_age >= RD && ((m_age - RD) % RR) == 0) p = 1'b1;
                end else begin
                    m_age = 0;
                end
            end
`else
            if (prev_held && p) p = 1'b0;
`endif
            m_s2 = m_s1;
            m_s1 = b;
            exp_q.push_back({p, m_level});
        end
    endtask

    task automatic hold(input logic b, input int n);
        for (int k = 0; k < n; k++) step(b, 1'b1);
    endtask

    // Monitor: every output cycle is compared against the head of the scoreboard.
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({t_pulse, btn_level} !== e) begin
                    n_err++;
                    $display("FAIL sb @%0t: got t_pulse=%b btn_level=%b, want t_pulse=%b btn_level=%b",
                             $time, t_pulse, btn_level, e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic lvl;
        int   len;
        int   nrst;
        int   guard;
        n_vec  = 0;
        n_err  = 0;
        btn_in = 1'b0;
        rst_n  = 1'b0;
        model_reset();

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        hold(1'b0, 4);

        // clean press, long hold, release
        hold(1'b1, 38);
        hold(1'b0, 15);
        // bounce on press
        hold(1'b1, 2);
        hold(1'b0, 1);
        hold(1'b1, 20);
        hold(1'b0, 15);
        // single-cycle glitch
        hold(1'b1, 1);
        hold(1'b0, 12);
        // release bounce while held
        hold(1'b1, 20);
        hold(1'b0, 2);
        hold(1'b1, 12);
        hold(1'b0, 15);
        // reset while qualifying a press, button still down
        hold(1'b1, 4);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        hold(1'b1, 15);
        hold(1'b0, 15);

        lvl = 1'b0;
        for (int s = 0; s < 250; s++) begin
            lvl = !lvl;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(D + 2, 45) : $urandom_range(1, D + 2);
            if ($urandom_range(0, 39) == 0) begin
                nrst = $urandom_range(1, 3);
                for (int k = 0; k < nrst; k++) step(lvl, 1'b0);
            end
            hold(lvl, len);
        end
        hold(1'b0, 12);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected outputs never checked, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
